// File: rtl/jtcop_gfx_slots.sv
// Four-slot graphics ROM responder: caches one 32-bit word per slot and fills misses from one
// SDRAM read port with round-robin arbitration. Define JTCOP_SLOTS_HOLD_EN to keep words valid while cs is low.
`timescale 1ns/1ps
module jtcop_gfx_slots #(
    parameter int          AW   = 17,
    parameter logic [21:0] OFF0 = 22'h0,
    parameter logic [21:0] OFF1 = 22'h0,
    parameter logic [21:0] OFF2 = 22'h0,
    parameter logic [21:0] OFF3 = 22'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      slot_cs,
    input  logic [4*AW-1:0] slot_addr,
    output logic [127:0]    slot_dout,
    output logic [3:0]      slot_ok,
    output logic            sdram_req,
    output logic [21:0]     sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [31:0]     data_read
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t        r_state;
    logic [1:0]    r_sel;
    logic [1:0]    r_rr;
    logic [AW-1:0] r_cap_addr;
    logic [AW-1:0] r_tag [4];
    logic [31:0]   r_dout [4];
    logic [3:0]    r_valid;

    logic [3:0]    w_miss;
    logic [3:0]    w_drop;
    logic [1:0]    w_pick;
    logic [AW-1:0] w_pick_addr;
    logic [21:0]   w_off;
    logic [21:0]   w_fetch_addr;

    // ok is a pure compare so it falls in the same cycle the requester moves its address.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_ok[i]            = slot_cs[i] & r_valid[i] & (slot_addr[i*AW +: AW] == r_tag[i]);
            slot_dout[i*32 +: 32] = r_dout[i];
        end
    end

    assign w_miss = slot_cs & ~slot_ok;

    // Scan from the farthest candidate to the nearest so the slot right after r_rr wins.
    always_comb begin
        w_pick = r_rr + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            if (w_miss[r_rr + 2'(k)]) w_pick = r_rr + 2'(k);
        end
    end

    always_comb begin
        case (w_pick)
            2'd0:    w_off = OFF0;
            2'd1:    w_off = OFF1;
            2'd2:    w_off = OFF2;
            default: w_off = OFF3;
        endcase
    end

    assign w_pick_addr  = slot_addr[int'(w_pick)*AW +: AW];
    assign w_fetch_addr = w_off + 22'({w_pick_addr, 1'b0});

`ifdef JTCOP_SLOTS_HOLD_EN
    assign w_drop = 4'b0000;
`else
    // A slot owning the in-flight transaction keeps its state until the fill lands.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_drop[i] = ~slot_cs[i] & ~((r_state != IDLE) && (r_sel == 2'(i)));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= 2'd0;
            r_rr       <= 2'd3;
            r_cap_addr <= '0;
            r_valid    <= 4'b0000;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            // NOTE: the data array is reset too, because slot_dout must read zero after reset.
            for (int i = 0; i < 4; i++) begin
                r_tag[i]  <= '0;
                r_dout[i] <= '0;
            end
        end else begin
            // NOTE: a fill below overrides this clear for the same bit; the last non-blocking write wins.
            r_valid <= r_valid & ~w_drop;
            case (r_state)
                IDLE: begin
                    if (|w_miss) begin
                        r_sel      <= w_pick;
                        r_cap_addr <= w_pick_addr;
                        sdram_addr <= w_fetch_addr;
                        sdram_req  <= 1'b1;
                        r_state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        r_state   <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_rdy) begin
                        r_dout[r_sel]  <= data_read;
                        r_tag[r_sel]   <= r_cap_addr;
                        r_valid[r_sel] <= 1'b1;
                        r_rr           <= r_sel;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcop_gfx_slots.sv
// Self-checking bench for jtcop_gfx_slots: directed scenarios plus randomized traffic
// against a behavioural cache/arbiter model. Honors JTCOP_SLOTS_HOLD_EN when defined.
`timescale 1ns/1ps
module tb_jtcop_gfx_slots;
    localparam int          AW   = 17;
    localparam logic [21:0] OFF0 = 22'h100000;
    localparam logic [21:0] OFF1 = 22'h040000;
    localparam logic [21:0] OFF2 = 22'h200000;
    localparam logic [21:0] OFF3 = 22'h3FFFF0;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      slot_cs;
    logic [4*AW-1:0] slot_addr;
    logic [127:0]    slot_dout;
    logic [3:0]      slot_ok;
    logic            sdram_req;
    logic [21:0]     sdram_addr;
    logic            sdram_ack;
    logic            data_rdy;
    logic [31:0]     data_read;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtcop_gfx_slots #(
        .AW(AW), .OFF0(OFF0), .OFF1(OFF1), .OFF2(OFF2), .OFF3(OFF3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slot_cs   (slot_cs),
        .slot_addr (slot_addr),
        .slot_dout (slot_dout),
        .slot_ok   (slot_ok),
        .sdram_req (sdram_req),
        .sdram_addr(sdram_addr),
        .sdram_ack (sdram_ack),
        .data_rdy  (data_rdy),
        .data_read (data_read)
    );

    // Expected SDRAM half-word address: slot base plus twice the word address, wrapped to 22 bits.
    function automatic logic [21:0] exp_sdram(input int slot, input logic [AW-1:0] a);
        int unsigned base;
        case (slot)
            0:       base = 32'(OFF0);
            1:       base = 32'(OFF1);
            2:       base = 32'(OFF2);
            default: base = 32'(OFF3);
        endcase
        return 22'((base + 2 * 32'(a)) % 32'h400000);
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        slot_cs   = 4'b0000;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 32 && timed_out; c++) begin
            if (sdram_req === 1'b1) timed_out = 1'b0;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
    endtask

    task automatic pulse_rdy(input logic [31:0] d);
        data_read = d;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        slot_cs   = 4'b1111;
        slot_addr = '0;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", sdram_req); end
        n_cmp++; if (sdram_addr !== 22'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", sdram_addr); end
        n_cmp++; if (slot_dout !== 128'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", slot_dout); end
        n_cmp++; if (slot_ok !== 4'b0000) begin n_err++; $display("FAIL reset_ok: got %b want 0000", slot_ok); end
        slot_cs = 4'b0000;
        rst     = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        slot_cs = 4'b0001;
        set_addr(0, 17'h00010);
        #1;
        n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL single_req_early: got %b want 0", sdram_req); end
        @(negedge clk);
        n_cmp++; if (sdram_req !== 1'b1) begin n_err++; $display("FAIL single_req: got %b want 1", sdram_req); end
        n_cmp++; if (sdram_addr !== 22'h100020) begin n_err++; $display("FAIL single_addr: got %h want 100020", sdram_addr); end
        @(negedge clk);
        n_cmp++; if (sdram_req !== 1'b1) begin n_err++; $display("FAIL single_req_hold: got %b want 1", sdram_req); end
        pulse_ack();
        n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL single_req_drop: got %b want 0", sdram_req); end
        @(negedge clk);
        n_cmp++; if (slot_ok[0] !== 1'b0) begin n_err++; $display("FAIL single_ok_early: got %b want 0", slot_ok[0]); end
        pulse_rdy(32'hDEADBEEF);
        n_cmp++; if (slot_dout[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_dout: got %h want deadbeef", slot_dout[31:0]); end
        n_cmp++; if (slot_ok[0] !== 1'b1) begin n_err++; $display("FAIL single_ok: got %b want 1", slot_ok[0]); end
        @(negedge clk);
        n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL single_no_refetch: got %b want 0", sdram_req); end
    endtask

    task automatic test_addr_change();
        logic [31:0] d;
        d = $urandom;
        set_addr(0, 17'h00011);
        #1;
        n_cmp++; if (slot_ok[0] !== 1'b0) begin n_err++; $display("FAIL chg_ok_drop: got %b want 0", slot_ok[0]); end
        @(negedge clk);
        n_cmp++; if (sdram_req !== 1'b1) begin n_err++; $display("FAIL chg_req: got %b want 1", sdram_req); end
        n_cmp++; if (sdram_addr !== 22'h100022) begin n_err++; $display("FAIL chg_addr: got %h want 100022", sdram_addr); end
        pulse_ack();
        pulse_rdy(d);
        n_cmp++; if (slot_dout[31:0] !== d) begin n_err++; $display("FAIL chg_dout: got %h want %h", slot_dout[31:0], d); end
        n_cmp++; if (slot_ok[0] !== 1'b1) begin n_err++; $display("FAIL chg_ok: got %b want 1", slot_ok[0]); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a [4];
        logic [31:0]   d [4];
        int            order1 [4] = '{0, 1, 2, 3};
        int            order2 [2] = '{0, 2};
        bit            to;
        logic [127:0]  exp_dout;
        do_reset();
        for (int i = 0; i < 3; i++) a[i] = AW'($urandom_range(0, (1 << AW) - 1));
        a[3] = 17'h00008;
        for (int i = 0; i < 4; i++) set_addr(i, a[i]);
        slot_cs = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            wait_req(to);
            n_cmp++; if (to) begin n_err++; $display("FAIL rr_timeout: got no req want req for slot %0d", order1[n]); end
            n_cmp++; if (sdram_addr !== exp_sdram(order1[n], a[order1[n]])) begin
                n_err++; $display("FAIL rr_order1: got %h want %h (slot %0d)", sdram_addr, exp_sdram(order1[n], a[order1[n]]), order1[n]);
            end
            d[order1[n]] = $urandom;
            pulse_ack();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse_rdy(d[order1[n]]);
            n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL rr_idle_gap: got %b want 0", sdram_req); end
        end
        @(negedge clk);
        n_cmp++; if (slot_ok !== 4'b1111) begin n_err++; $display("FAIL rr_all_ok: got %b want 1111", slot_ok); end
        for (int i = 0; i < 3; i += 2) begin
            a[i] = a[i] + 1'b1;
            set_addr(i, a[i]);
        end
        for (int n = 0; n < 2; n++) begin
            wait_req(to);
            n_cmp++; if (to) begin n_err++; $display("FAIL rr2_timeout: got no req want req for slot %0d", order2[n]); end
            n_cmp++; if (sdram_addr !== exp_sdram(order2[n], a[order2[n]])) begin
                n_err++; $display("FAIL rr_order2: got %h want %h (slot %0d)", sdram_addr, exp_sdram(order2[n], a[order2[n]]), order2[n]);
            end
            d[order2[n]] = $urandom;
            pulse_ack();
            pulse_rdy(d[order2[n]]);
        end
        for (int i = 0; i < 4; i++) exp_dout[i*32 +: 32] = d[i];
        n_cmp++; if (slot_ok !== 4'b1111) begin n_err++; $display("FAIL rr2_all_ok: got %b want 1111", slot_ok); end
        n_cmp++; if (slot_dout !== exp_dout) begin n_err++; $display("FAIL rr_dout: got %h want %h", slot_dout, exp_dout); end
    endtask

    task automatic test_cs_drop();
        logic [AW-1:0] a;
        logic [31:0]   d;
        bit            to;
        do_reset();
        a = AW'($urandom_range(0, (1 << AW) - 1));
        d = $urandom;
        set_addr(1, a);
        slot_cs = 4'b0010;
        wait_req(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL drop_timeout: got no req want req"); end
        n_cmp++; if (sdram_addr !== exp_sdram(1, a)) begin n_err++; $display("FAIL drop_addr: got %h want %h", sdram_addr, exp_sdram(1, a)); end
        pulse_ack();
        slot_cs = 4'b0000;
        @(negedge clk);
        pulse_rdy(d);
        n_cmp++; if (slot_ok[1] !== 1'b0) begin n_err++; $display("FAIL drop_ok: got %b want 0", slot_ok[1]); end
        n_cmp++; if (slot_dout[63:32] !== d) begin n_err++; $display("FAIL drop_dout: got %h want %h", slot_dout[63:32], d); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL drop_no_req: got %b want 0", sdram_req); end
        end
        slot_cs = 4'b0010;
        #1;
`ifdef JTCOP_SLOTS_HOLD_EN
        n_cmp++; if (slot_ok[1] !== 1'b1) begin n_err++; $display("FAIL hold_ok: got %b want 1", slot_ok[1]); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL hold_no_req: got %b want 0", sdram_req); end
        end
`else
        n_cmp++; if (slot_ok[1] !== 1'b0) begin n_err++; $display("FAIL nohold_ok: got %b want 0", slot_ok[1]); end
        @(negedge clk);
        n_cmp++; if (sdram_req !== 1'b1) begin n_err++; $display("FAIL nohold_req: got %b want 1", sdram_req); end
        n_cmp++; if (sdram_addr !== exp_sdram(1, a)) begin n_err++; $display("FAIL nohold_addr: got %h want %h", sdram_addr, exp_sdram(1, a)); end
        d = $urandom;
        pulse_ack();
        pulse_rdy(d);
        n_cmp++; if (slot_ok[1] !== 1'b1) begin n_err++; $display("FAIL nohold_refill_ok: got %b want 1", slot_ok[1]); end
        n_cmp++; if (slot_dout[63:32] !== d) begin n_err++; $display("FAIL nohold_refill_dout: got %h want %h", slot_dout[63:32], d); end
`endif
    endtask

    task automatic test_reset_wait_data();
        logic [AW-1:0] a;
        bit            to;
        do_reset();
        a = AW'($urandom_range(0, (1 << AW) - 1));
        set_addr(0, a);
        slot_cs = 4'b0001;
        wait_req(to);
        n_cmp++; if (to) begin n_err++; $display("FAIL rstwd_timeout: got no req want req"); end
        pulse_ack();
        slot_cs = 4'b0000;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL rstwd_req: got %b want 0", sdram_req); end
        pulse_rdy(32'hCAFEF00D);
        n_cmp++; if (slot_dout !== 128'h0) begin n_err++; $display("FAIL rstwd_dout: got %h want 0", slot_dout); end
        n_cmp++; if (slot_ok !== 4'b0000) begin n_err++; $display("FAIL rstwd_ok: got %b want 0000", slot_ok); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL rstwd_idle_req: got %b want 0", sdram_req); end
        end
        slot_cs = 4'b0001;
        #1;
        n_cmp++; if (slot_ok[0] !== 1'b0) begin n_err++; $display("FAIL rstwd_valid: got %b want 0", slot_ok[0]); end
        @(negedge clk);
        n_cmp++; if (sdram_req !== 1'b1) begin n_err++; $display("FAIL rstwd_new_req: got %b want 1", sdram_req); end
        pulse_ack();
        pulse_rdy(32'h12345678);
        n_cmp++; if (slot_dout[31:0] !== 32'h12345678) begin n_err++; $display("FAIL rstwd_refill: got %h want 12345678", slot_dout[31:0]); end
    endtask

    // Randomized traffic: the model tracks a per-slot cache line and one outstanding fetch.
    task automatic test_random(input int cycles);
        bit            m_valid [4];
        logic [AW-1:0] m_tag [4];
        logic [31:0]   m_data [4];
        int            last, phase, sel, prev_phase, prev_sel;
        logic [AW-1:0] cap;
        logic [21:0]   exp_addr;
        logic [3:0]    exp_ok, miss;
        logic [127:0]  exp_dout;
        bit            found;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
            set_addr(i, AW'($urandom_range(0, 3)));
        end
        last = 3; phase = 0; sel = 0; cap = '0; exp_addr = '0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 4; i++) begin
                exp_ok[i] = slot_cs[i] && m_valid[i] && (slot_addr[i*AW +: AW] == m_tag[i]);
                exp_dout[i*32 +: 32] = m_data[i];
            end
            n_cmp++; if (slot_ok !== exp_ok) begin n_err++; $display("FAIL rand_ok @%0d: got %b want %b", c, slot_ok, exp_ok); end
            n_cmp++; if (slot_dout !== exp_dout) begin n_err++; $display("FAIL rand_dout @%0d: got %h want %h", c, slot_dout, exp_dout); end
            n_cmp++; if (sdram_req !== (phase == 1)) begin n_err++; $display("FAIL rand_req @%0d: got %b want %b", c, sdram_req, phase == 1); end
            if (phase == 1) begin
                n_cmp++; if (sdram_addr !== exp_addr) begin n_err++; $display("FAIL rand_addr @%0d: got %h want %h", c, sdram_addr, exp_addr); end
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) slot_cs[i] = ~slot_cs[i];
                if ($urandom_range(0, 9) == 0) set_addr(i, AW'($urandom_range(0, 3)));
            end
            sdram_ack = (phase == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            data_rdy  = (phase == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            data_read = $urandom;
            prev_phase = phase;
            prev_sel   = sel;
            for (int i = 0; i < 4; i++)
                miss[i] = slot_cs[i] && !(m_valid[i] && slot_addr[i*AW +: AW] == m_tag[i]);
`ifdef JTCOP_SLOTS_HOLD_EN
`else
            for (int i = 0; i < 4; i++)
                if (!slot_cs[i] && !(prev_phase != 0 && prev_sel == i)) m_valid[i] = 1'b0;
`endif
            case (phase)
                0: if (miss != 4'b0000) begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && miss[(last + k) % 4]) begin
                            sel   = (last + k) % 4;
                            found = 1'b1;
                        end
                    end
                    cap      = slot_addr[sel*AW +: AW];
                    exp_addr = exp_sdram(sel, cap);
                    phase    = 1;
                end
                1: if (sdram_ack) phase = 2;
                default: if (data_rdy) begin
                    m_data[sel]  = data_read;
                    m_tag[sel]   = cap;
                    m_valid[sel] = 1'b1;
                    last         = sel;
                    phase        = 0;
                end
            endcase
            @(negedge clk);
        end
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_addr_change();
        test_round_robin();
        test_cs_drop();
        test_reset_wait_data();
        test_random(1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
